id_ex_hazard_stage: RTL and testbench
=====================================

Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection.
- Sits between the decode stage and the EX-stage forwarding logic. It supplies ID_EX_rs/ID_EX_rt to forwarding and ID_EX_* control/data to the ALU operand muxes.
- On a load-use hazard it stalls PC and IF/ID and injects a one-cycle bubble.
- Also supports a branch flush, a global hold (memory busy) and a saturating stall-event counter.

Parameters:
- DATA_W, 32, width of register-file read data and sign-extended immediate.
- CNT_W, 16, width of the stall-event counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- IF_ID_rs  in  5  rs field of instruction in decode
- IF_ID_rt  in  5  rt field of instruction in decode
- IF_ID_rd  in  5  rd field of instruction in decode
- ID_ReadData1  in  DATA_W  register-file rs data
- ID_ReadData2  in  DATA_W  register-file rt data
- ID_Imm  in  DATA_W  sign-extended immediate
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst  in  1 each  decoded control
- ID_ALUOp  in  2  decoded ALU op class
- Flush  in  1  squash decode instruction (taken branch/jump)
- Hold  in  1  freeze whole stage (downstream busy)
- ID_EX_rs, ID_EX_rt, ID_EX_rd  out  5 each  registered fields
- ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm  out  DATA_W each  registered data
- ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc, ID_EX_RegDst  out  1 each  registered control
- ID_EX_ALUOp  out  2  registered ALU op
- PCWrite  out  1  PC update enable (combinational)
- IF_ID_Write  out  1  IF/ID register enable (combinational)
- Stall_Count  out  CNT_W  load-use stall cycles, saturating

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All ID_EX_* outputs and Stall_Count go to 0.
  - The reset bubble is a NOP: all control bits are 0.
- Hazard (combinational): Hazard = ID_EX_MemRead & (ID_EX_rt != 0) & ((ID_EX_rt == IF_ID_rs) | (ID_EX_rt == IF_ID_rt)).
- Per-cycle action, evaluated in priority order on each rising edge:
  1. Hold=1: all ID_EX_* registers keep their value. PCWrite=0, IF_ID_Write=0. Stall_Count unchanged.
  2. Flush=1: ID_EX_* control bits and ID_EX_ALUOp load 0; fields and data load from inputs (don't-care). PCWrite=1, IF_ID_Write=1, so the redirect proceeds. A simultaneous Hazard is ignored and does not count.
  3. Hazard=1: bubble is inserted (control and ALUOp load 0; fields and data load from inputs). PCWrite=0, IF_ID_Write=0. Stall_Count increments.
  4. Otherwise: every ID_EX_* register loads its ID_* / IF_ID_* input. PCWrite=1, IF_ID_Write=1.
- PCWrite and IF_ID_Write are combinational from Hold, Flush and Hazard. They are valid during reset: Hazard=0 because ID_EX_MemRead=0.
- Latency: one cycle from ID_* inputs to ID_EX_* outputs.
- Load-use stall length is exactly one cycle. After the bubble, ID_EX_MemRead=0, so Hazard deasserts and the held decode instruction advances. Forwarding then supplies the load data from MEM/WB.
- Stall_Count saturates at 2^CNT_W-1 and never wraps.
- Reset asserted mid-stall: outputs clear immediately. Once PCWrite=1 on the next cycle, a fresh stall is only raised by a new load.
- Register 0 never triggers a stall, even with ID_EX_MemRead=1.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all ID_EX_* = 0, Stall_Count=0, PCWrite=1, IF_ID_Write=1. Release -> next edge loads inputs.
- Pass-through: add rs=1, rt=2, rd=3, RegWrite=1, ALUOp=2'b10, ReadData1=0x11 -> one edge later ID_EX_rs=1, ID_EX_rd=3, ID_EX_RegWrite=1, ID_EX_ReadData1=0x11.
- Load-use: lw rt=8 (MemRead=1) into ID_EX, decode presents rs=8 ->
  - PCWrite=0 and IF_ID_Write=0 for one cycle.
  - Next edge: ID_EX control all 0 and Stall_Count=1.
  - Following edge: the dependent instruction loads with no further stall.
- Load to r0: lw rt=0 then consumer with rs=0 -> no stall, PCWrite=1, Stall_Count=0.
- Flush vs hazard: hazard condition plus Flush=1 -> PCWrite=1, ID_EX control 0, Stall_Count unchanged.
- Hold and saturation:
  - Hold=1 for 3 cycles during load-use -> ID_EX_* frozen, PCWrite=0, no count. Release -> single-cycle stall resumes.
  - With CNT_W=2, after 5 stalls -> Stall_Count=3.

Source files
------------

// File: rtl/id_ex_hazard_stage_if.sv
// rtl/id_ex_hazard_stage_if.sv - decode-side and ID/EX-side signal bundle for the hazard stage
//
// Purpose: carries the decode-stage instruction fields, operands and control
// into the ID/EX register. It carries the registered ID/EX values, the stall
// enables and the stall counter back out.
// Modports:
//   slave  - the ID/EX stage: consumes IF_ID_*, ID_*, Flush and Hold, and
//            drives ID_EX_*, PCWrite, IF_ID_Write and Stall_Count.
//   master - the decode side / environment: the mirror image of slave.
interface id_ex_hazard_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [4:0]        IF_ID_rs;
  logic [4:0]        IF_ID_rt;
  logic [4:0]        IF_ID_rd;
  logic [DATA_W-1:0] ID_ReadData1;
  logic [DATA_W-1:0] ID_ReadData2;
  logic [DATA_W-1:0] ID_Imm;
  logic              ID_RegWrite;
  logic              ID_MemRead;
  logic              ID_MemWrite;
  logic              ID_MemToReg;
  logic              ID_ALUSrc;
  logic              ID_RegDst;
  logic [1:0]        ID_ALUOp;
  logic              Flush;
  logic              Hold;

  logic [4:0]        ID_EX_rs;
  logic [4:0]        ID_EX_rt;
  logic [4:0]        ID_EX_rd;
  logic [DATA_W-1:0] ID_EX_ReadData1;
  logic [DATA_W-1:0] ID_EX_ReadData2;
  logic [DATA_W-1:0] ID_EX_Imm;
  logic              ID_EX_RegWrite;
  logic              ID_EX_MemRead;
  logic              ID_EX_MemWrite;
  logic              ID_EX_MemToReg;
  logic              ID_EX_ALUSrc;
  logic              ID_EX_RegDst;
  logic [1:0]        ID_EX_ALUOp;
  logic              PCWrite;
  logic              IF_ID_Write;
  logic [CNT_W-1:0]  Stall_Count;

  modport slave (
    input  IF_ID_rs, IF_ID_rt, IF_ID_rd,
    input  ID_ReadData1, ID_ReadData2, ID_Imm,
    input  ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst,
    input  ID_ALUOp, Flush, Hold,
    output ID_EX_rs, ID_EX_rt, ID_EX_rd,
    output ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm,
    output ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg,
    output ID_EX_ALUSrc, ID_EX_RegDst, ID_EX_ALUOp,
    output PCWrite, IF_ID_Write, Stall_Count
  );

  modport master (
    output IF_ID_rs, IF_ID_rt, IF_ID_rd,
    output ID_ReadData1, ID_ReadData2, ID_Imm,
    output ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst,
    output ID_ALUOp, Flush, Hold,
    input  ID_EX_rs, ID_EX_rt, ID_EX_rd,
    input  ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm,
    input  ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg,
    input  ID_EX_ALUSrc, ID_EX_RegDst, ID_EX_ALUOp,
    input  PCWrite, IF_ID_Write, Stall_Count
  );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// rtl/id_ex_hazard_stage.sv - ID/EX pipeline register with load-use hazard detection
//
// Purpose: registers the decode instruction into ID/EX. It detects a load-use
// dependency on the instruction already in ID/EX and injects a one-cycle
// bubble while freezing PC and IF/ID. It also honours a branch Flush and a
// global Hold, and counts load-use stall cycles with a saturating counter.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - id_ex_hazard_stage_if.slave; its DATA_W/CNT_W must match this module's
module id_ex_hazard_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  id_ex_hazard_stage_if.slave        bus
);

  logic hazard;
  logic bubble;
  logic count_en;

  // A load whose destination is read by the decode instruction cannot be
  // forwarded in time. r0 is hard-wired zero, so it is never a real dependency.
  assign hazard = bus.ID_EX_MemRead && (bus.ID_EX_rt != 5'd0) &&
                  ((bus.ID_EX_rt == bus.IF_ID_rs) || (bus.ID_EX_rt == bus.IF_ID_rt));

  // Flush outranks the hazard: the dependent instruction is being squashed
  // anyway, so the redirect must go ahead and nothing is counted.
  assign bubble   = bus.Flush || hazard;
  assign count_en = !bus.Hold && !bus.Flush && hazard &&
                    (bus.Stall_Count != {CNT_W{1'b1}});

  always_comb begin
    bus.PCWrite     = 1'b1;
    bus.IF_ID_Write = 1'b1;
    if (bus.Hold || (!bus.Flush && hazard)) begin
      bus.PCWrite     = 1'b0;
      bus.IF_ID_Write = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ID_EX_rs        <= 5'd0;
      bus.ID_EX_rt        <= 5'd0;
      bus.ID_EX_rd        <= 5'd0;
      bus.ID_EX_ReadData1 <= '0;
      bus.ID_EX_ReadData2 <= '0;
      bus.ID_EX_Imm       <= '0;
      bus.ID_EX_RegWrite  <= 1'b0;
      bus.ID_EX_MemRead   <= 1'b0;
      bus.ID_EX_MemWrite  <= 1'b0;
      bus.ID_EX_MemToReg  <= 1'b0;
      bus.ID_EX_ALUSrc    <= 1'b0;
      bus.ID_EX_RegDst    <= 1'b0;
      bus.ID_EX_ALUOp     <= 2'b00;
    end else if (!bus.Hold) begin
      // Fields and data always follow decode; only control is squashed by a bubble.
      bus.ID_EX_rs        <= bus.IF_ID_rs;
      bus.ID_EX_rt        <= bus.IF_ID_rt;
      bus.ID_EX_rd        <= bus.IF_ID_rd;
      bus.ID_EX_ReadData1 <= bus.ID_ReadData1;
      bus.ID_EX_ReadData2 <= bus.ID_ReadData2;
      bus.ID_EX_Imm       <= bus.ID_Imm;
      bus.ID_EX_RegWrite  <= bubble ? 1'b0 : bus.ID_RegWrite;
      bus.ID_EX_MemRead   <= bubble ? 1'b0 : bus.ID_MemRead;
      bus.ID_EX_MemWrite  <= bubble ? 1'b0 : bus.ID_MemWrite;
      bus.ID_EX_MemToReg  <= bubble ? 1'b0 : bus.ID_MemToReg;
      bus.ID_EX_ALUSrc    <= bubble ? 1'b0 : bus.ID_ALUSrc;
      bus.ID_EX_RegDst    <= bubble ? 1'b0 : bus.ID_RegDst;
      bus.ID_EX_ALUOp     <= bubble ? 2'b00 : bus.ID_ALUOp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Stall_Count <= '0;
    end else if (count_en) begin
      bus.Stall_Count <= bus.Stall_Count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// tb/tb_id_ex_hazard_stage.sv - directed self-checking bench for id_ex_hazard_stage
module tb_id_ex_hazard_stage;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_hazard_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
  id_ex_hazard_stage_if #(.DATA_W(DATA_W), .CNT_W(2))     bus_s ();

  id_ex_hazard_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  id_ex_hazard_stage #(.DATA_W(DATA_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );

  // The narrow-counter instance sees exactly the same stimulus.
  assign bus_s.IF_ID_rs     = bus.IF_ID_rs;
  assign bus_s.IF_ID_rt     = bus.IF_ID_rt;
  assign bus_s.IF_ID_rd     = bus.IF_ID_rd;
  assign bus_s.ID_ReadData1 = bus.ID_ReadData1;
  assign bus_s.ID_ReadData2 = bus.ID_ReadData2;
  assign bus_s.ID_Imm       = bus.ID_Imm;
  assign bus_s.ID_RegWrite  = bus.ID_RegWrite;
  assign bus_s.ID_MemRead   = bus.ID_MemRead;
  assign bus_s.ID_MemWrite  = bus.ID_MemWrite;
  assign bus_s.ID_MemToReg  = bus.ID_MemToReg;
  assign bus_s.ID_ALUSrc    = bus.ID_ALUSrc;
  assign bus_s.ID_RegDst    = bus.ID_RegDst;
  assign bus_s.ID_ALUOp     = bus.ID_ALUOp;
  assign bus_s.Flush        = bus.Flush;
  assign bus_s.Hold         = bus.Hold;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ctrl = {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst}
  task automatic set_ins(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [5:0] ctrl, input logic [1:0] aluop,
                         input logic [31:0] rd1);
    bus.IF_ID_rs     = rs;
    bus.IF_ID_rt     = rt;
    bus.IF_ID_rd     = rd;
    bus.ID_RegWrite  = ctrl[5];
    bus.ID_MemRead   = ctrl[4];
    bus.ID_MemWrite  = ctrl[3];
    bus.ID_MemToReg  = ctrl[2];
    bus.ID_ALUSrc    = ctrl[1];
    bus.ID_RegDst    = ctrl[0];
    bus.ID_ALUOp     = aluop;
    bus.ID_ReadData1 = rd1;
    bus.ID_ReadData2 = rd1 ^ 32'hFFFF_0000;
    bus.ID_Imm       = rd1 + 32'd4;
  endtask

  task automatic test_reset();
    logic [5:0] ctl;
    logic [15:0] cnt;
    rst_n = 1'b0;
    bus.Flush = 1'b0;
    bus.Hold  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ins(5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom) | 6'b010000,
              2'($urandom), $urandom);
      step();
    end
    ctl = {bus.ID_EX_RegWrite, bus.ID_EX_MemRead, bus.ID_EX_MemWrite,
           bus.ID_EX_MemToReg, bus.ID_EX_ALUSrc, bus.ID_EX_RegDst};
    total++; if (ctl !== 6'd0) begin bad++; $display("FAIL reset_ctrl got=%b exp=000000", ctl); end
    total++; if (bus.ID_EX_ALUOp !== 2'd0) begin bad++; $display("FAIL reset_aluop got=%b exp=00", bus.ID_EX_ALUOp); end
    total++; if (bus.ID_EX_rs !== 5'd0 || bus.ID_EX_rt !== 5'd0 || bus.ID_EX_rd !== 5'd0) begin
      bad++; $display("FAIL reset_fields got=%0d/%0d/%0d exp=0/0/0", bus.ID_EX_rs, bus.ID_EX_rt, bus.ID_EX_rd);
    end
    total++; if (bus.ID_EX_ReadData1 !== 32'd0 || bus.ID_EX_ReadData2 !== 32'd0 || bus.ID_EX_Imm !== 32'd0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", bus.ID_EX_ReadData1, bus.ID_EX_ReadData2, bus.ID_EX_Imm);
    end
    cnt = bus.Stall_Count;
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt); end
    total++; if (bus.PCWrite !== 1'b1 || bus.IF_ID_Write !== 1'b1) begin
      bad++; $display("FAIL reset_enables got=%b%b exp=11", bus.PCWrite, bus.IF_ID_Write);
    end
    set_ins(5'd12, 5'd13, 5'd14, 6'b100011, 2'b01, 32'hCAFE_0001);
    rst_n = 1'b1;
    step();
    total++; if (bus.ID_EX_rs !== 5'd12 || bus.ID_EX_rd !== 5'd14 || bus.ID_EX_RegWrite !== 1'b1 ||
                 bus.ID_EX_ALUOp !== 2'b01 || bus.ID_EX_ReadData1 !== 32'hCAFE_0001) begin
      bad++; $display("FAIL reset_release_load got rs=%0d rd=%0d rw=%b op=%b d1=%h exp rs=12 rd=14 rw=1 op=01 d1=cafe0001",
                      bus.ID_EX_rs, bus.ID_EX_rd, bus.ID_EX_RegWrite, bus.ID_EX_ALUOp, bus.ID_EX_ReadData1);
    end
  endtask

  task automatic test_pass_through();
    set_ins(5'd1, 5'd2, 5'd3, 6'b100001, 2'b10, 32'h11);
    step();
    total++; if (bus.ID_EX_rs !== 5'd1 || bus.ID_EX_rt !== 5'd2 || bus.ID_EX_rd !== 5'd3) begin
      bad++; $display("FAIL pass_fields got=%0d/%0d/%0d exp=1/2/3", bus.ID_EX_rs, bus.ID_EX_rt, bus.ID_EX_rd);
    end
    total++; if (bus.ID_EX_RegWrite !== 1'b1 || bus.ID_EX_RegDst !== 1'b1 || bus.ID_EX_MemRead !== 1'b0 ||
                 bus.ID_EX_ALUOp !== 2'b10) begin
      bad++; $display("FAIL pass_ctrl got rw=%b rdst=%b mr=%b op=%b exp rw=1 rdst=1 mr=0 op=10",
                      bus.ID_EX_RegWrite, bus.ID_EX_RegDst, bus.ID_EX_MemRead, bus.ID_EX_ALUOp);
    end
    total++; if (bus.ID_EX_ReadData1 !== 32'h11 || bus.ID_EX_ReadData2 !== 32'hFFFF_0011 || bus.ID_EX_Imm !== 32'h15) begin
      bad++; $display("FAIL pass_data got=%h/%h/%h exp=00000011/ffff0011/00000015",
                      bus.ID_EX_ReadData1, bus.ID_EX_ReadData2, bus.ID_EX_Imm);
    end
  endtask

  task automatic test_load_use();
    set_ins(5'd4, 5'd8, 5'd0, 6'b110110, 2'b00, 32'h100);   // lw r8
    step();
    set_ins(5'd8, 5'd9, 5'd10, 6'b100001, 2'b10, 32'h200);  // add uses r8
    #1;
    total++; if (bus.PCWrite !== 1'b0 || bus.IF_ID_Write !== 1'b0) begin
      bad++; $display("FAIL lu_stall_enables got=%b%b exp=00", bus.PCWrite, bus.IF_ID_Write);
    end
    step();
    total++; if (bus.ID_EX_RegWrite !== 1'b0 || bus.ID_EX_MemRead !== 1'b0 || bus.ID_EX_MemToReg !== 1'b0 ||
                 bus.ID_EX_ALUSrc !== 1'b0 || bus.ID_EX_RegDst !== 1'b0 || bus.ID_EX_ALUOp !== 2'b00) begin
      bad++; $display("FAIL lu_bubble got rw=%b mr=%b m2r=%b src=%b dst=%b op=%b exp all 0",
                      bus.ID_EX_RegWrite, bus.ID_EX_MemRead, bus.ID_EX_MemToReg, bus.ID_EX_ALUSrc,
                      bus.ID_EX_RegDst, bus.ID_EX_ALUOp);
    end
    total++; if (bus.Stall_Count !== 16'd1) begin bad++; $display("FAIL lu_count got=%0d exp=1", bus.Stall_Count); end
    total++; if (bus.PCWrite !== 1'b1) begin bad++; $display("FAIL lu_after_bubble_pcwrite got=%b exp=1", bus.PCWrite); end
    step();
    total++; if (bus.ID_EX_rs !== 5'd8 || bus.ID_EX_RegWrite !== 1'b1 || bus.ID_EX_ALUOp !== 2'b10 ||
                 bus.Stall_Count !== 16'd1) begin
      bad++; $display("FAIL lu_dependent_load got rs=%0d rw=%b op=%b cnt=%0d exp rs=8 rw=1 op=10 cnt=1",
                      bus.ID_EX_rs, bus.ID_EX_RegWrite, bus.ID_EX_ALUOp, bus.Stall_Count);
    end
  endtask

  task automatic test_load_r0();
    set_ins(5'd4, 5'd0, 5'd0, 6'b110110, 2'b00, 32'h300);   // lw r0
    step();
    set_ins(5'd0, 5'd0, 5'd11, 6'b100001, 2'b10, 32'h400);
    #1;
    total++; if (bus.PCWrite !== 1'b1 || bus.IF_ID_Write !== 1'b1) begin
      bad++; $display("FAIL r0_enables got=%b%b exp=11", bus.PCWrite, bus.IF_ID_Write);
    end
    step();
    total++; if (bus.ID_EX_RegWrite !== 1'b1 || bus.ID_EX_rd !== 5'd11 || bus.Stall_Count !== 16'd1) begin
      bad++; $display("FAIL r0_no_stall got rw=%b rd=%0d cnt=%0d exp rw=1 rd=11 cnt=1",
                      bus.ID_EX_RegWrite, bus.ID_EX_rd, bus.Stall_Count);
    end
  endtask

  task automatic test_flush_vs_hazard();
    set_ins(5'd4, 5'd5, 5'd0, 6'b110110, 2'b00, 32'h500);   // lw r5
    step();
    set_ins(5'd5, 5'd6, 5'd7, 6'b100001, 2'b10, 32'h600);
    bus.Flush = 1'b1;
    #1;
    total++; if (bus.PCWrite !== 1'b1 || bus.IF_ID_Write !== 1'b1) begin
      bad++; $display("FAIL flush_enables got=%b%b exp=11", bus.PCWrite, bus.IF_ID_Write);
    end
    step();
    bus.Flush = 1'b0;
    total++; if (bus.ID_EX_RegWrite !== 1'b0 || bus.ID_EX_RegDst !== 1'b0 || bus.ID_EX_ALUOp !== 2'b00 ||
                 bus.Stall_Count !== 16'd1) begin
      bad++; $display("FAIL flush_bubble got rw=%b dst=%b op=%b cnt=%0d exp rw=0 dst=0 op=00 cnt=1",
                      bus.ID_EX_RegWrite, bus.ID_EX_RegDst, bus.ID_EX_ALUOp, bus.Stall_Count);
    end
  endtask

  task automatic test_hold();
    set_ins(5'd4, 5'd6, 5'd0, 6'b110110, 2'b00, 32'h700);   // lw r6
    step();
    set_ins(5'd9, 5'd6, 5'd12, 6'b100001, 2'b10, 32'h800);  // uses r6 as rt
    bus.Hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus.PCWrite !== 1'b0 || bus.IF_ID_Write !== 1'b0) begin
        bad++; $display("FAIL hold_enables[%0d] got=%b%b exp=00", i, bus.PCWrite, bus.IF_ID_Write);
      end
      step();
      total++; if (bus.ID_EX_MemRead !== 1'b1 || bus.ID_EX_rt !== 5'd6 || bus.ID_EX_ReadData1 !== 32'h700 ||
                   bus.Stall_Count !== 16'd1) begin
        bad++; $display("FAIL hold_frozen[%0d] got mr=%b rt=%0d d1=%h cnt=%0d exp mr=1 rt=6 d1=700 cnt=1",
                        i, bus.ID_EX_MemRead, bus.ID_EX_rt, bus.ID_EX_ReadData1, bus.Stall_Count);
      end
    end
    bus.Hold = 1'b0;
    #1;
    total++; if (bus.PCWrite !== 1'b0) begin bad++; $display("FAIL hold_release_stall got=%b exp=0", bus.PCWrite); end
    step();
    total++; if (bus.ID_EX_MemRead !== 1'b0 || bus.ID_EX_RegWrite !== 1'b0 || bus.Stall_Count !== 16'd2 ||
                 bus.PCWrite !== 1'b1) begin
      bad++; $display("FAIL hold_bubble got mr=%b rw=%b cnt=%0d pcw=%b exp mr=0 rw=0 cnt=2 pcw=1",
                      bus.ID_EX_MemRead, bus.ID_EX_RegWrite, bus.Stall_Count, bus.PCWrite);
    end
    step();
    total++; if (bus.ID_EX_rd !== 5'd12 || bus.ID_EX_RegWrite !== 1'b1 || bus.Stall_Count !== 16'd2) begin
      bad++; $display("FAIL hold_advance got rd=%0d rw=%b cnt=%0d exp rd=12 rw=1 cnt=2",
                      bus.ID_EX_rd, bus.ID_EX_RegWrite, bus.Stall_Count);
    end
  endtask

  task automatic test_saturation();
    // Both counters stand at 2 here; five more stalls give 7 wide, 3 saturated.
    for (int i = 0; i < 5; i++) begin
      set_ins(5'd1, 5'd20, 5'd0, 6'b110110, 2'b00, 32'h900);
      step();
      set_ins(5'd20, 5'd2, 5'd21, 6'b100001, 2'b10, 32'hA00);
      step();
      total++; if (bus_s.Stall_Count !== 2'd3) begin
        bad++; $display("FAIL sat_count[%0d] got=%0d exp=3", i, bus_s.Stall_Count);
      end
    end
    total++; if (bus.Stall_Count !== 16'd7) begin bad++; $display("FAIL wide_count got=%0d exp=7", bus.Stall_Count); end
  endtask

  task automatic test_reset_mid_stall();
    set_ins(5'd4, 5'd7, 5'd0, 6'b110110, 2'b00, 32'hB00);   // lw r7
    step();
    set_ins(5'd7, 5'd3, 5'd15, 6'b100001, 2'b10, 32'hC00);
    #1;
    total++; if (bus.PCWrite !== 1'b0) begin bad++; $display("FAIL mid_pre_stall got=%b exp=0", bus.PCWrite); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.ID_EX_MemRead !== 1'b0 || bus.ID_EX_rt !== 5'd0 || bus.Stall_Count !== 16'd0 ||
                 bus.PCWrite !== 1'b1 || bus.IF_ID_Write !== 1'b1) begin
      bad++; $display("FAIL mid_async_clear got mr=%b rt=%0d cnt=%0d en=%b%b exp mr=0 rt=0 cnt=0 en=11",
                      bus.ID_EX_MemRead, bus.ID_EX_rt, bus.Stall_Count, bus.PCWrite, bus.IF_ID_Write);
    end
    step();
    rst_n = 1'b1;
    step();
    total++; if (bus.ID_EX_rs !== 5'd7 || bus.ID_EX_RegWrite !== 1'b1 || bus.Stall_Count !== 16'd0 ||
                 bus.PCWrite !== 1'b1) begin
      bad++; $display("FAIL mid_no_restall got rs=%0d rw=%b cnt=%0d pcw=%b exp rs=7 rw=1 cnt=0 pcw=1",
                      bus.ID_EX_rs, bus.ID_EX_RegWrite, bus.Stall_Count, bus.PCWrite);
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_load_r0();
    test_flush_vs_hazard();
    test_hold();
    test_saturation();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
